alu_cmd_sequencer: RTL and testbench

- Initiator side of the 8-bit ALU interface.
- Accepts register-level commands over a valid/ready channel and keeps a 4-entry x 8-bit register file.
- Drives op/enable/operands to an external combinational ALU, waits a programmable settle time, then captures the 9-bit ALU result into the destination register and a carry flag.
- Returns the result on a valid/ready response channel.
- Sits between a test/stimulus master or small controller and the ALU.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_regfile.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcodes, FSM state encoding and datapath field widths.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 9;
    localparam int RIDX_W = 2;
    localparam int NREG   = 4;
    localparam int CNT_W  = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: two asynchronous read ports, one synchronous
// write port, synchronous clear.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RIDX_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RIDX_W-1:0] ra,
    input  logic [RIDX_W-1:0] rb,
    output logic [DATA_W-1:0] rda,
    output logic [DATA_W-1:0] rdb
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rda = mem[ra];
    assign rdb = mem[rb];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the 8-bit ALU interface: runs register-level
// commands against an external combinational ALU, one at a time.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [RIDX_W-1:0] cmd_dst,
    input  logic [RIDX_W-1:0] cmd_sa,
    input  logic [RIDX_W-1:0] cmd_sb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              alu_en,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              carry
);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
        $error("ALU_LAT must be in 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [RIDX_W-1:0] dst_q;
    logic [DATA_W-1:0] rda;
    logic [DATA_W-1:0] rdb;
    logic              we;
    logic [RIDX_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              accept;
    logic              done;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ST_ISSUE) && (cnt == '0);

    // Both write sources share one port; they can never coincide.
    always_comb begin
        we    = 1'b0;
        waddr = cmd_dst;
        wdata = cmd_imm;
        if (accept && cmd_load) begin
            we = 1'b1;
        end else if (done) begin
            we    = 1'b1;
            waddr = dst_q;
            wdata = alu_res[DATA_W-1:0];
        end
    end

    alu_seq_regfile u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .ra    (cmd_sa),
        .rb    (cmd_sb),
        .rda   (rda),
        .rdb   (rdb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dst_q     <= '0;
            carry     <= 1'b0;
            alu_en    <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept && cmd_load) begin
                        rsp_data  <= {1'b0, cmd_imm};
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (accept) begin
                        alu_op <= cmd_op;
                        alu_a  <= rda;
                        alu_b  <= rdb;
                        alu_en <= 1'b1;
                        dst_q  <= cmd_dst;
                        cnt    <= LAT_M1;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (done) begin
                        carry     <= alu_res[RES_W-1];
                        rsp_data  <= alu_res;
                        alu_en    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: one instance with ALU_LAT=1 and one
// with ALU_LAT=3, each driving its own behavioural ALU.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1;
    logic       cmd_valid, cmd_load, rsp_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_sa, cmd_sb;
    logic [7:0] cmd_imm;
    int         sel;

    logic       cv0, cv1, rr0, rr1;
    logic       cr0, cr1, en0, en1, rv0, rv1, cy0, cy1;
    logic [2:0] op0, op1;
    logic [7:0] a0, a1, b0, b1;
    logic [8:0] res0, res1, rd0, rd1;

    logic       cr, en, rv, cy;
    logic [2:0] aop;
    logic [7:0] aa, ab;
    logic [8:0] rd;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] q[$];

    function automatic logic [8:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            3'b010:  return {1'b0, a} + 9'd1;
            3'b011:  return {1'b0, a} - 9'd1;
            3'b100:  return {1'b0, a & b};
            3'b101:  return {1'b0, a | b};
            3'b110:  return {1'b0, a ^ b};
            default: return {1'b0, ~a};
        endcase
    endfunction

    assign res0 = alu_f(op0, a0, b0);
    assign res1 = alu_f(op1, a1, b1);
    assign cv0  = cmd_valid && (sel == 0);
    assign cv1  = cmd_valid && (sel == 1);
    assign rr0  = rsp_ready && (sel == 0);
    assign rr1  = rsp_ready && (sel == 1);

    always_comb begin
        cr  = (sel == 0) ? cr0 : cr1;
        en  = (sel == 0) ? en0 : en1;
        rv  = (sel == 0) ? rv0 : rv1;
        cy  = (sel == 0) ? cy0 : cy1;
        aop = (sel == 0) ? op0 : op1;
        aa  = (sel == 0) ? a0  : a1;
        ab  = (sel == 0) ? b0  : b1;
        rd  = (sel == 0) ? rd0 : rd1;
    end

    alu_cmd_sequencer #(.ALU_LAT(1)) dut0 (
        .clk(clk), .rst(rst0), .cmd_valid(cv0), .cmd_ready(cr0),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
        .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_imm(cmd_imm),
        .alu_en(en0), .alu_op(op0), .alu_a(a0), .alu_b(b0),
        .alu_res(res0), .rsp_valid(rv0), .rsp_ready(rr0),
        .rsp_data(rd0), .carry(cy0)
    );

    alu_cmd_sequencer #(.ALU_LAT(3)) dut1 (
        .clk(clk), .rst(rst1), .cmd_valid(cv1), .cmd_ready(cr1),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
        .cmd_sa(cmd_sa), .cmd_sb(cmd_sb), .cmd_imm(cmd_imm),
        .alu_en(en1), .alu_op(op1), .alu_a(a1), .alu_b(b1),
        .alu_res(res1), .rsp_valid(rv1), .rsp_ready(rr1),
        .rsp_data(rd1), .carry(cy1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic ld, input logic [2:0] op,
                        input logic [1:0] d, input logic [1:0] s,
                        input logic [1:0] b, input logic [7:0] im,
                        input logic [8:0] exp);
        int n = 0;
        q.push_back(exp);
        cmd_load = ld; cmd_op = op; cmd_dst = d;
        cmd_sa = s; cmd_sb = b; cmd_imm = im;
        cmd_valid = 1'b1;
        while (!cr && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cr) chk("cmd_accept_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Entered in the first cycle after the accept edge.
    task automatic collect(input int elat, input int eens,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic ecy, input bit is_op);
        int         cyc = 1;
        int         ens = 0;
        bit         stable = 1'b1;
        logic [7:0] fa = '0, fb = '0;
        logic [2:0] fo = '0;
        logic [8:0] exp;
        while (!rv && cyc < 60) begin
            if (en) begin
                if (ens == 0) begin
                    fa = aa; fb = ab; fo = aop;
                end else if (aa !== fa || ab !== fb || aop !== fo) begin
                    stable = 1'b0;
                end
                ens++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rsp_latency", cyc, elat);
        chk("alu_en_cycles", ens, eens);
        if (is_op) begin
            chk("alu_a", fa, ea);
            chk("alu_b", fb, eb);
            chk("operands_stable", stable, 1);
        end
        if (q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            exp = q.pop_front();
            chk("rsp_data", rd, exp);
        end
        chk("carry", cy, ecy);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", rv, 0);
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [1:0] d, s, b;
        logic [7:0] imm;
        logic [8:0] rsp;
        logic       cy;
        logic [7:0] ea, eb;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{1, 3'd0, 0, 0, 0, 8'h0F, 9'h00F, 0, 8'h00, 8'h00};
        tv[1]  = '{1, 3'd0, 1, 0, 0, 8'h01, 9'h001, 0, 8'h00, 8'h00};
        tv[2]  = '{0, 3'd0, 2, 0, 1, 8'h00, 9'h010, 0, 8'h0F, 8'h01};
        tv[3]  = '{1, 3'd0, 0, 0, 0, 8'hFF, 9'h0FF, 0, 8'h00, 8'h00};
        tv[4]  = '{0, 3'd0, 0, 0, 1, 8'h00, 9'h100, 1, 8'hFF, 8'h01};
        tv[5]  = '{0, 3'd2, 3, 0, 1, 8'h00, 9'h001, 0, 8'h00, 8'h01};
        tv[6]  = '{0, 3'd5, 1, 2, 3, 8'h00, 9'h011, 0, 8'h10, 8'h01};
        tv[7]  = '{0, 3'd3, 0, 0, 3, 8'h00, 9'h1FF, 1, 8'h00, 8'h01};
        tv[8]  = '{1, 3'd0, 1, 0, 0, 8'hAA, 9'h0AA, 1, 8'h00, 8'h00};
        tv[9]  = '{1, 3'd0, 2, 0, 0, 8'h0F, 9'h00F, 1, 8'h00, 8'h00};
        tv[10] = '{0, 3'd4, 3, 1, 2, 8'h00, 9'h00A, 0, 8'hAA, 8'h0F};
        tv[11] = '{0, 3'd7, 0, 3, 3, 8'h00, 9'h0F5, 0, 8'h0A, 8'h0A};

        sel = 0;
        rst0 = 1'b1; rst1 = 1'b1;
        cmd_valid = 1'b0; cmd_load = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0;
        cmd_imm = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cr, 0);
        chk("reset_rsp_valid", rv, 0);
        chk("reset_alu_en", en, 0);
        chk("reset_carry", cy, 0);
        chk("reset_rsp_data", rd, 0);
        chk("reset_alu_a", aa, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cr, 1);

        for (int i = 0; i < 12; i++) begin
            send(tv[i].ld, tv[i].op, tv[i].d, tv[i].s, tv[i].b,
                 tv[i].imm, tv[i].rsp);
            collect(tv[i].ld ? 1 : 2, tv[i].ld ? 0 : 1,
                    tv[i].ea, tv[i].eb, tv[i].cy, !tv[i].ld);
        end

        // xor r0 = r1 ^ r2 with the response held off for 5 cycles
        begin
            int n = 0;
            send(0, 3'd6, 0, 1, 2, 8'h00, 9'h0A5);
            while (!rv && n < 20) begin
                @(negedge clk);
                n++;
            end
            q.push_back(9'h055);
            cmd_load = 1'b1; cmd_dst = 2'd3; cmd_imm = 8'h55;
            cmd_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                chk("bp_rsp_valid", rv, 1);
                chk("bp_rsp_data", rd, 9'h0A5);
                chk("bp_cmd_ready", cr, 0);
                @(negedge clk);
            end
            chk("bp_rsp_data_final", rd, q.pop_front());
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("bp_ready_after_hs", cr, 1);
            chk("bp_no_early_rsp", rv, 0);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("bp_pending_rsp_valid", rv, 1);
            chk("bp_pending_rsp_data", rd, q.pop_front());
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end

        sel = 1;
        @(negedge clk);
        send(1, 3'd0, 0, 0, 0, 8'h05, 9'h005);
        collect(1, 0, 8'h00, 8'h00, 0, 0);
        send(1, 3'd0, 1, 0, 0, 8'h07, 9'h007);
        collect(1, 0, 8'h00, 8'h00, 0, 0);
        send(0, 3'd1, 2, 0, 1, 8'h00, 9'h1FE);
        collect(4, 3, 8'h05, 8'h07, 1, 1);

        // abort an add partway through its settle time
        begin
            bit seen = 1'b0;
            send(0, 3'd0, 3, 0, 1, 8'h00, 9'h00C);
            @(negedge clk);
            rst1 = 1'b1;
            @(negedge clk);
            chk("abort_alu_en", en, 0);
            chk("abort_rsp_valid", rv, 0);
            chk("abort_carry", cy, 0);
            chk("abort_cmd_ready", cr, 0);
            rst1 = 1'b0;
            q.delete();
            rsp_ready = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (rv) seen = 1'b1;
            end
            rsp_ready = 1'b0;
            chk("abort_no_response", seen, 0);
        end
        send(0, 3'd5, 0, 0, 1, 8'h00, 9'h000);
        collect(4, 3, 8'h00, 8'h00, 0, 1);
        send(0, 3'd5, 1, 2, 3, 8'h00, 9'h000);
        collect(4, 3, 8'h00, 8'h00, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
